// File: rtl/xillybus_write_stream_fifo_if.sv
// ----------------------------------------------------------------------------
// xillybus_write_stream_fifo_if
//
// Purpose:
//   Bundles the signals around xillybus_write_stream_fifo: the Xillybus write
//   channel coming from xillybus_core, the valid/ready stream going to the
//   accelerator, and the status outputs (level, overflow).
//
// Signals:
//   user_w_data_w  [31:0]  write data from core
//   user_w_wren_w          write strobe from core
//   user_w_open_w          host file open (level)
//   user_w_full_w          full flag back to core
//   m_data         [31:0]  stream data (valid while m_valid)
//   m_valid                stream data valid
//   m_ready                accelerator accepts m_data
//   level          [AW:0]  FIFO occupancy, 0..DEPTH
//   overflow               sticky write-while-full flag
//   m_last                 final-word marker (only with XWSF_LAST_EN defined)
//
// Modports:
//   slave   - the FIFO itself
//   master  - its surroundings (core + accelerator, or a testbench)
// ----------------------------------------------------------------------------
interface xillybus_write_stream_fifo_if #(
    parameter int unsigned AW = 4
) ();

    logic [31:0] user_w_data_w;
    logic        user_w_wren_w;
    logic        user_w_open_w;
    logic        user_w_full_w;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [AW:0] level;
    logic        overflow;
`ifdef XWSF_LAST_EN
    logic        m_last;
`endif

    modport slave (
        input  user_w_data_w,
        input  user_w_wren_w,
        input  user_w_open_w,
        output user_w_full_w,
        output m_data,
        output m_valid,
        input  m_ready,
        output level,
        output overflow
`ifdef XWSF_LAST_EN
        , output m_last
`endif
    );

    modport master (
        output user_w_data_w,
        output user_w_wren_w,
        output user_w_open_w,
        input  user_w_full_w,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  level,
        input  overflow
`ifdef XWSF_LAST_EN
        , input m_last
`endif
    );

endinterface

// File: rtl/xillybus_write_stream_fifo.sv
// ----------------------------------------------------------------------------
// xillybus_write_stream_fifo
//
// Purpose:
//   Buffers one 32-bit host-to-FPGA Xillybus write channel and presents it to
//   an HLS accelerator as a first-word-fall-through valid/ready stream. Drives
//   the channel full flag back to xillybus_core, keeps a sticky overflow flag
//   for writes attempted while full.
//
// Parameters:
//   DEPTH  FIFO entries, power of two, >= 2
//   AW     pointer width, must equal log2(DEPTH)
//
// Ports:
//   bus_clk_w  single clock for the whole block
//   bus_rst_w  asynchronous, active-high reset (contents discarded)
//   bus        xillybus_write_stream_fifo_if.slave (see interface file)
//
// Configuration macro:
//   XWSF_LAST_EN  when defined, bus.m_last marks the final buffered word once
//                 the host has closed the file. Without it the stream has no
//                 end marker and user_w_open_w is ignored entirely.
// ----------------------------------------------------------------------------
module xillybus_write_stream_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                           bus_clk_w,
    input  logic                           bus_rst_w,
    xillybus_write_stream_fifo_if.slave    bus
);

    localparam logic [AW:0]   LevelFull = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LevelOne  = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne    = AW'(1);

    logic [31:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;

    logic          w_full;
    logic          w_valid;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AW:0]   w_level_nxt;

    // Full depends only on registered level, so there is no combinational
    // path from the core's write strobe back to its full input.
    assign w_full   = (r_level == LevelFull);
    assign w_valid  = (r_level != '0);
    assign w_wr_acc = bus.user_w_wren_w && !w_full;
    assign w_rd_acc = w_valid && bus.m_ready;

    // Simultaneous accepted write and pop leave the occupancy unchanged.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + LevelOne;
            2'b01:   w_level_nxt = r_level - LevelOne;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge bus_clk_w or posedge bus_rst_w) begin
        if (bus_rst_w) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            r_level <= w_level_nxt;
            // Rejected write: the word is dropped, only the sticky flag moves.
            if (bus.user_w_wren_w && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; validity is tracked by r_level alone.
    always_ff @(posedge bus_clk_w) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.user_w_data_w;
        end
    end

    assign bus.user_w_full_w = w_full;
    assign bus.m_valid       = w_valid;
    assign bus.m_data        = r_mem[r_rd_ptr];
    assign bus.level         = r_level;
    assign bus.overflow      = r_overflow;

`ifdef XWSF_LAST_EN
    // Last word only once the host has closed; a reopen withdraws the marker
    // combinationally because more data may still follow.
    assign bus.m_last = w_valid && (r_level == LevelOne) && !bus.user_w_open_w;
`else
    logic w_unused_open;
    assign w_unused_open = bus.user_w_open_w;
`endif

endmodule
